// File: rtl/hc_595_pkg.sv
// Shared constants, FSM state type and frame helpers for the 74HC595 link receiver.
package hc_595_pkg;

  localparam int FRAME_BITS = 14;
  localparam int SEL_W      = 6;
  localparam int SEG_W      = 8;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] CNT_FULL = 4'd14;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    OVER
  } state_e;

  function automatic state_e state_of(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)            return IDLE;
    else if (cnt < CNT_FULL)  return SHIFT;
    else if (cnt == CNT_FULL) return FULL;
    else                      return OVER;
  endfunction

  // seg[7] is shifted first after sel, so it lands just above sel in sr.
  function automatic logic [SEG_W-1:0] seg_of(input logic [FRAME_BITS-1:0] sr);
    logic [SEG_W-1:0] g;
    for (int i = 0; i < SEG_W; i++) g[i] = sr[FRAME_BITS-1-i];
    return g;
  endfunction

endpackage

// File: rtl/hc_595_sync.sv
// Two-flop synchronizer with an optional third flop for rising-edge detection.
module hc_595_sync #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   RISE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

  generate
    if (RISE_EN) begin : g_rise
      logic s3_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) s3_q <= RST_VAL;
        else     s3_q <= s2_q;
      end
      assign rise = s2_q & ~s3_q;
    end else begin : g_no_rise
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hc_595_rx.sv
// Receiver for a chained pair of 74HC595s: rebuilds sel/seg from ds/shcp/stcp
// and flags complete, malformed and abandoned frames.
module hc_595_rx
  import hc_595_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             ds,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             disp_en,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic ds_s2, shcp_rise, stcp_rise, oe_s2;
  logic unused_ds_rise, unused_oe_rise, unused_shcp_s2, unused_stcp_s2;

  hc_595_sync #(.RST_VAL(1'b0), .RISE_EN(1'b0)) u_sync_ds (
    .clk(sys_clk), .rst(sys_rst), .d(ds), .q(ds_s2), .rise(unused_ds_rise));
  hc_595_sync #(.RST_VAL(1'b0), .RISE_EN(1'b1)) u_sync_shcp (
    .clk(sys_clk), .rst(sys_rst), .d(shcp), .q(unused_shcp_s2), .rise(shcp_rise));
  hc_595_sync #(.RST_VAL(1'b0), .RISE_EN(1'b1)) u_sync_stcp (
    .clk(sys_clk), .rst(sys_rst), .d(stcp), .q(unused_stcp_s2), .rise(stcp_rise));
  hc_595_sync #(.RST_VAL(1'b1), .RISE_EN(1'b0)) u_sync_oe (
    .clk(sys_clk), .rst(sys_rst), .d(oe), .q(oe_s2), .rise(unused_oe_rise));

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  disp_en_q, disp_en_d;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    sel_d     = sel_q;
    seg_d     = seg_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    disp_en_d = ~oe_s2;

    // Latch sees pre-shift sr/state even when shcp rises in the same cycle.
    if (stcp_rise) begin
      sel_d   = sr_q[SEL_W-1:0];
      seg_d   = seg_of(sr_q);
      valid_d = (state_q == FULL);
      err_d   = (state_q != FULL);
      cnt_d   = '0;
      idle_d  = '0;
    end

    if (shcp_rise) begin
      sr_d   = {ds_s2, sr_q[FRAME_BITS-1:1]};
      idle_d = '0;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + 4'd1;
    end else if (!stcp_rise && state_q == SHIFT) begin
      if (idle_q == IDLE_LAST) begin
        err_d  = 1'b1;
        cnt_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    state_d = state_of(cnt_d);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      state_q   <= IDLE;
      sel_q     <= '0;
      seg_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      disp_en_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      disp_en_q <= disp_en_d;
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign disp_en     = disp_en_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_hc_595_rx.sv
// Directed bench for hc_595_rx: full, short, long, timed-out, overlapped and
// reset-interrupted frames.
module tb_hc_595_rx;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b1;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       disp_en, frame_valid, frame_err;

  int total = 0;
  int bad   = 0;

  hc_595_rx #(.TIMEOUT_CYC(50)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp),
    .oe(oe), .sel(sel), .seg(seg), .disp_en(disp_en),
    .frame_valid(frame_valid), .frame_err(frame_err));

  always #10 sys_clk = ~sys_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, want finish before 5ms");
    $fatal(1);
  end

  // Serial order: sel[0]..sel[5], then seg[7]..seg[0].
  function automatic logic [13:0] mk(input logic [5:0] s, input logic [7:0] g);
    logic [13:0] v;
    for (int i = 0; i < 6; i++) v[i] = s[i];
    for (int i = 0; i < 8; i++) v[6+i] = g[7-i];
    return v;
  endfunction

  task automatic send_bit(input logic b);
    ds = b;
    repeat (2) @(negedge sys_clk);
    shcp = 1'b1;
    repeat (2) @(negedge sys_clk);
    shcp = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [13:0] v, input int from, input int to);
    for (int i = from; i < to; i++) send_bit(v[i]);
  endtask

  // Pulses stcp and records pulse counts and the cycle of the first pulse.
  task automatic latch_capture(output int nv, output int ne, output int first);
    nv = 0; ne = 0; first = -1;
    stcp = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge sys_clk); #1;
      if ((frame_valid || frame_err) && first < 0) first = c;
      nv += int'(frame_valid);
      ne += int'(frame_err);
      if (c == 1) stcp = 1'b0;
    end
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    total += 5;
    if (sel !== 6'h00)      begin bad++; $display("FAIL rst_sel: got %h want 00", sel); end
    if (seg !== 8'h00)      begin bad++; $display("FAIL rst_seg: got %h want 00", seg); end
    if (disp_en !== 1'b0)   begin bad++; $display("FAIL rst_disp_en: got %b want 0", disp_en); end
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_full_frame();
    int nv, ne, first;
    do_reset();
    send_bits(mk(6'b000001, 8'hC0), 0, 14);
    latch_capture(nv, ne, first);
    total += 5;
    if (first !== 2)    begin bad++; $display("FAIL full_latency: got %0d want 2", first); end
    if (nv !== 1)       begin bad++; $display("FAIL full_valid_cnt: got %0d want 1", nv); end
    if (ne !== 0)       begin bad++; $display("FAIL full_err_cnt: got %0d want 0", ne); end
    if (sel !== 6'h01)  begin bad++; $display("FAIL full_sel: got %h want 01", sel); end
    if (seg !== 8'hC0)  begin bad++; $display("FAIL full_seg: got %h want c0", seg); end
  endtask

  task automatic test_short_frame();
    int nv, ne, first;
    do_reset();
    send_bits(14'h3FFF, 0, 10);
    latch_capture(nv, ne, first);
    total += 4;
    if (ne !== 1)       begin bad++; $display("FAIL short_err_cnt: got %0d want 1", ne); end
    if (nv !== 0)       begin bad++; $display("FAIL short_valid_cnt: got %0d want 0", nv); end
    if (sel !== 6'h30)  begin bad++; $display("FAIL short_sel: got %h want 30", sel); end
    if (seg !== 8'hFF)  begin bad++; $display("FAIL short_seg: got %h want ff", seg); end
  endtask

  task automatic test_long_frame();
    int nv, ne, first;
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bits(mk(6'h2A, 8'h5B), 0, 14);
    latch_capture(nv, ne, first);
    total += 4;
    if (ne !== 1)       begin bad++; $display("FAIL long_err_cnt: got %0d want 1", ne); end
    if (nv !== 0)       begin bad++; $display("FAIL long_valid_cnt: got %0d want 0", nv); end
    if (sel !== 6'h2A)  begin bad++; $display("FAIL long_sel: got %h want 2a", sel); end
    if (seg !== 8'h5B)  begin bad++; $display("FAIL long_seg: got %h want 5b", seg); end
  endtask

  task automatic test_timeout();
    int nv, ne, first, found;
    do_reset();
    send_bits(mk(6'h15, 8'h3C), 0, 7);
    found = -1;
    for (int j = 1; j <= 100; j++) begin
      @(posedge sys_clk); #1;
      if (frame_err && found < 0) found = j;
    end
    @(negedge sys_clk);
    total += 1;
    if (found < 48 || found > 50) begin
      bad++; $display("FAIL timeout_cycle: got %0d want 49 (48..50)", found);
    end
    send_bits(mk(6'h12, 8'hE7), 0, 14);
    latch_capture(nv, ne, first);
    total += 3;
    if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL timeout_next_pulses: got v=%0d e=%0d want v=1 e=0", nv, ne); end
    if (sel !== 6'h12)  begin bad++; $display("FAIL timeout_next_sel: got %h want 12", sel); end
    if (seg !== 8'hE7)  begin bad++; $display("FAIL timeout_next_seg: got %h want e7", seg); end
  endtask

  task automatic test_back_to_back();
    int nv, ne, first;
    logic [13:0] b;
    b = mk(6'h33, 8'h96);
    do_reset();
    send_bits(mk(6'h0F, 8'hA7), 0, 14);
    ds = b[0];
    repeat (2) @(negedge sys_clk);
    shcp = 1'b1;
    stcp = 1'b1;
    nv = 0; ne = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      nv += int'(frame_valid);
      ne += int'(frame_err);
      if (c == 1) begin shcp = 1'b0; stcp = 1'b0; end
    end
    @(negedge sys_clk);
    total += 3;
    if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL b2b_pulses: got v=%0d e=%0d want v=1 e=0", nv, ne); end
    if (sel !== 6'h0F)  begin bad++; $display("FAIL b2b_sel: got %h want 0f", sel); end
    if (seg !== 8'hA7)  begin bad++; $display("FAIL b2b_seg: got %h want a7", seg); end
    send_bits(b, 1, 14);
    latch_capture(nv, ne, first);
    total += 3;
    if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL b2b_next_pulses: got v=%0d e=%0d want v=1 e=0", nv, ne); end
    if (sel !== 6'h33)  begin bad++; $display("FAIL b2b_next_sel: got %h want 33", sel); end
    if (seg !== 8'h96)  begin bad++; $display("FAIL b2b_next_seg: got %h want 96", seg); end
  endtask

  task automatic test_reset_mid_frame();
    int nv, ne, first;
    do_reset();
    oe = 1'b0;
    repeat (4) @(negedge sys_clk);
    total += 1;
    if (disp_en !== 1'b1) begin bad++; $display("FAIL oe_disp_en: got %b want 1", disp_en); end
    send_bits(mk(6'h3F, 8'h81), 0, 14);
    latch_capture(nv, ne, first);
    send_bits(mk(6'h2D, 8'h6E), 0, 9);
    sys_rst = 1'b1;
    #1;
    total += 5;
    if (sel !== 6'h00)  begin bad++; $display("FAIL midrst_sel: got %h want 00", sel); end
    if (seg !== 8'h00)  begin bad++; $display("FAIL midrst_seg: got %h want 00", seg); end
    if (disp_en !== 1'b0) begin bad++; $display("FAIL midrst_disp_en: got %b want 0", disp_en); end
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL midrst_pulses: got v=%b e=%b want 0 0", frame_valid, frame_err);
    end
    repeat (2) @(negedge sys_clk);
    if (disp_en !== 1'b0) begin bad++; $display("FAIL midrst_disp_en_hold: got %b want 0", disp_en); end
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    total += 2;
    if (disp_en !== 1'b0) begin bad++; $display("FAIL release_disp_en_early: got %b want 0", disp_en); end
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    if (disp_en !== 1'b1) begin bad++; $display("FAIL release_disp_en: got %b want 1", disp_en); end
    @(negedge sys_clk);
    send_bits(mk(6'h04, 8'h99), 0, 14);
    latch_capture(nv, ne, first);
    total += 3;
    if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL after_rst_pulses: got v=%0d e=%0d want v=1 e=0", nv, ne); end
    if (sel !== 6'h04)  begin bad++; $display("FAIL after_rst_sel: got %h want 04", sel); end
    if (seg !== 8'h99)  begin bad++; $display("FAIL after_rst_seg: got %h want 99", seg); end
    oe = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
